store_align_unit: RTL and testbench
===================================

// Module: store_align_unit
// PURPOSE
// - Store-side counterpart of the load extension path: converts an RV32 store (SB/SH/SW) into
//   word-aligned data-memory write beats with byte strobes.
// - Sits between the MEM stage and the data-memory write port. Misaligned stores crossing a
//   word boundary are split into two beats. Invalid funct3 is rejected with a fault pulse.
// PARAMETERS
// - REG_WIDTH_IN_BYTE  4                      register/bus width in bytes; only 4 is supported
// - REG_WIDTH_IN_BIT   REG_WIDTH_IN_BYTE*8    derived data width
// - ADDR_WIDTH         32                     byte-address width
// PORTS
// - clk         in   1           single clock, rising edge
// - rst         in   1           asynchronous, active-high reset
// - req_valid   in   1           store request valid
// - req_ready   out  1           unit can accept a request; 1 only in IDLE
// - req_funct3  in   3           store funct3: 000=SB, 001=SH, 010=SW; any other value is invalid
// - req_addr    in   ADDR_WIDTH  byte address
// - req_data    in   32          rs2 value; the low byte/half/word is used
// - mem_valid   out  1           write beat valid
// - mem_ready   in   1           memory accepts the beat
// - mem_addr    out  ADDR_WIDTH  word-aligned beat address ([1:0]=00)
// - mem_wdata   out  32          lane-aligned write data
// - mem_wstrb   out  4           byte strobes, bit i = byte lane i
// - done        out  1           one-cycle pulse: store fully written
// - fault       out  1           one-cycle pulse: request rejected; no memory traffic
// BEHAVIOUR
// - Reset (async): state IDLE. mem_valid, mem_addr, mem_wdata, mem_wstrb, done and fault are
//   all 0. req_ready is 1 once reset deasserts.
// - States and transitions:
//   - IDLE -> BEAT0 on accept (req_valid & req_ready) with a legal request.
//   - BEAT0 -> BEAT1 when mem_ready is high and a second beat is needed; otherwise BEAT0 -> IDLE.
//   - BEAT1 -> IDLE when mem_ready is high.
// - Request decode at accept:
//   - off = addr[1:0].
//   - mask = 0001 for SB, 0011 for SH, 1111 for SW.
//   - strb8 = {4'b0,mask} << off (8 bits).
//   - data64 = {32'b0,data} << 8*off. Bytes of req_data above the access size are masked by strb.
// - Beats:
//   - BEAT0: addr = {req_addr[31:2],2'b00}, wstrb = strb8[3:0], wdata = data64[31:0].
//   - BEAT1 (only when strb8[7:4]!=0): addr = BEAT0 addr + 4, modulo 2^ADDR_WIDTH, so
//     0xFFFF_FFFC wraps to 0x0000_0000. wstrb = strb8[7:4], wdata = data64[63:32].
// - Timing:
//   - mem_* registers load on the accept edge; mem_valid is 1 in the next cycle.
//   - All mem_* outputs stay stable while mem_valid & !mem_ready.
//   - Beat handshake = mem_valid & mem_ready.
//   - The BEAT1 payload loads on the BEAT0 handshake edge, with no idle cycle between beats.
//   - On the final handshake edge: mem_valid<=0, done<=1 for one cycle, state<=IDLE.
//     req_ready is therefore 1 in the done cycle, and a new request can be accepted in that cycle.
//   - Minimum latency, aligned store with mem_ready held high: accept edge N, beat in cycle N+1,
//     done in cycle N+2.
// - Illegal request (funct3 not 000/001/010): accepted, and fault<=1 for one cycle. State stays
//   IDLE and mem_valid stays 0.
// - Only one pending request exists at a time. req_* inputs are sampled only on the accept edge.
// - rst asserted mid-transaction: the beat is abandoned, the FSM returns to IDLE at once, and
//   no done or fault is produced.
// - done and fault are never high in the same cycle.
// CONFIGURATION
// - Macro STORE_ALIGN_MISALIGNED_SPLIT_EN:
//   - Defined: word-crossing stores are split into BEAT0+BEAT1 as above.
//   - Undefined: any request with strb8[7:4]!=0 is treated as illegal (fault pulse, no mem
//     traffic) and BEAT1 logic is not built. Misaligned stores that stay within one word (for
//     example SH at off=1) still complete as a single beat.
// TESTING
// - SW addr=0x1000 data=0xDEADBEEF, mem_ready=1 -> one beat: addr 0x1000, wstrb 1111,
//   wdata 0xDEADBEEF; done at N+2.
// - SB addr=0x2003 data=0x123456AB -> one beat: addr 0x2000, wstrb 1000, wdata[31:24]=0xAB.
// - SW addr=0x3002 data=0xAABBCCDD with SPLIT_EN:
//   - Beat 0: addr 0x3000, wstrb 1100, wdata[31:16]=0xCCDD.
//   - Beat 1: addr 0x3004, wstrb 0011, wdata[15:0]=0xAABB.
//   - Without SPLIT_EN: fault pulse, mem_valid stays 0.
// - SH addr=0xFFFF_FFFF, SPLIT_EN -> BEAT0 addr 0xFFFF_FFFC wstrb 1000; BEAT1 addr 0x0000_0000
//   wstrb 0001.
// - funct3=100 -> fault pulse for 1 cycle, no beat. A request in the following cycle is accepted.
// - mem_ready held 0 for 5 cycles during BEAT0: mem_* outputs stay constant. Asserting rst in
//   cycle 3 -> mem_valid=0 and req_ready=1 after release, with no done.

Source files
------------

// File: rtl/store_align_unit.sv
// store_align_unit: turns an RV32 SB/SH/SW into word-aligned write beats with byte strobes.
// Ports: clk, rst (async, active-high); req_* store request in (valid/ready handshake);
//   mem_* write beat out (valid/ready handshake); done/fault one-cycle completion pulses.
// Macro STORE_ALIGN_MISALIGNED_SPLIT_EN: when defined, word-crossing stores are split
//   into two beats; when undefined, they are rejected with a fault pulse.
module store_align_unit #(
  parameter int REG_WIDTH_IN_BYTE = 4,
  parameter int REG_WIDTH_IN_BIT  = REG_WIDTH_IN_BYTE * 8,
  parameter int ADDR_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_funct3,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [REG_WIDTH_IN_BIT-1:0]  req_data,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [REG_WIDTH_IN_BIT-1:0]  mem_wdata,
  output logic [REG_WIDTH_IN_BYTE-1:0] mem_wstrb,
  output logic                         done,
  output logic                         fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1
  } state_t;

  state_t                         r_state;
  logic                           r_mem_valid;
  logic [ADDR_WIDTH-1:0]          r_mem_addr;
  logic [REG_WIDTH_IN_BIT-1:0]    r_mem_wdata;
  logic [REG_WIDTH_IN_BYTE-1:0]   r_mem_wstrb;
  logic                           r_done;
  logic                           r_fault;

  logic [1:0]                     w_off;
  logic [3:0]                     w_mask;
  logic                           w_f3_ok;
  logic [7:0]                     w_strb8;
  logic                           w_legal;
  logic [REG_WIDTH_IN_BIT-1:0]    w_data_lo;
  logic [ADDR_WIDTH-1:0]          w_word_addr;

  assign w_off       = req_addr[1:0];
  assign w_word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    w_mask  = 4'b0000;
    w_f3_ok = 1'b0;
    unique case (1'b1)
      (req_funct3 == 3'b000): begin
        w_mask  = 4'b0001;
        w_f3_ok = 1'b1;
      end
      (req_funct3 == 3'b001): begin
        w_mask  = 4'b0011;
        w_f3_ok = 1'b1;
      end
      (req_funct3 == 3'b010): begin
        w_mask  = 4'b1111;
        w_f3_ok = 1'b1;
      end
      default: begin
        w_mask  = 4'b0000;
        w_f3_ok = 1'b0;
      end
    endcase
  end

  assign w_strb8 = {4'b0000, w_mask} << w_off;

`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
  logic [2*REG_WIDTH_IN_BIT-1:0]  w_data64;
  logic [REG_WIDTH_IN_BIT-1:0]    r_hi_data;
  logic [REG_WIDTH_IN_BYTE-1:0]   r_hi_strb;

  assign w_data64  = {{REG_WIDTH_IN_BIT{1'b0}}, req_data} << {w_off, 3'b000};
  assign w_data_lo = w_data64[REG_WIDTH_IN_BIT-1:0];
  assign w_legal   = w_f3_ok;
`else
  // Only the low word is ever written, so the upper shift-out is dropped.
  assign w_data_lo = req_data << {w_off, 3'b000};
  assign w_legal   = w_f3_ok && (w_strb8[7:4] == 4'b0000);
`endif

  assign req_ready = (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
      r_hi_data   <= '0;
      r_hi_strb   <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_legal) begin
              r_state     <= S_BEAT0;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= w_word_addr;
              r_mem_wdata <= w_data_lo;
              r_mem_wstrb <= w_strb8[3:0];
`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
              r_hi_data   <= w_data64[2*REG_WIDTH_IN_BIT-1:REG_WIDTH_IN_BIT];
              r_hi_strb   <= w_strb8[7:4];
`endif
            end else begin
              r_fault <= 1'b1;
            end
          end
        end
        S_BEAT0: begin
          if (mem_ready) begin
`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
            if (r_hi_strb != '0) begin
              // Second beat follows back-to-back; address wraps naturally.
              r_state     <= S_BEAT1;
              r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(4);
              r_mem_wdata <= r_hi_data;
              r_mem_wstrb <= r_hi_strb;
            end else begin
              r_state     <= S_IDLE;
              r_mem_valid <= 1'b0;
              r_done      <= 1'b1;
            end
`else
            r_state     <= S_IDLE;
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
`endif
          end
        end
`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
        S_BEAT1: begin
          if (mem_ready) begin
            r_state     <= S_IDLE;
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`endif
        default: begin
          r_state     <= S_IDLE;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign done      = r_done;
  assign fault     = r_fault;

endmodule

// File: tb/tb_store_align_unit.sv
// tb_store_align_unit: scoreboard bench for store_align_unit.
// Byte-wise reference model; beats popped and compared as they hand off.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        fault;

`ifdef STORE_ALIGN_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  store_align_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  beat_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, output bit flt,
                                output int nb, output beat_t b0,
                                output beat_t b1);
    int sz;
    logic [31:0] ba, d0, d1;
    logic [3:0] s0, s1;
    flt = 1'b0;
    nb  = 0;
    d0 = '0; d1 = '0; s0 = '0; s1 = '0;
    case (f3)
      3'b000:  sz = 1;
      3'b001:  sz = 2;
      3'b010:  sz = 4;
      default: sz = 0;
    endcase
    for (int i = 0; i < sz; i++) begin
      ba = a + 32'(i);
      if (ba[31:2] == a[31:2]) begin
        d0[8*ba[1:0] +: 8] = d[8*i +: 8];
        s0[ba[1:0]] = 1'b1;
      end else begin
        d1[8*ba[1:0] +: 8] = d[8*i +: 8];
        s1[ba[1:0]] = 1'b1;
      end
    end
    b0 = '{addr: {a[31:2], 2'b00}, data: d0, strb: s0};
    b1 = '{addr: {a[31:2], 2'b00} + 32'd4, data: d1, strb: s1};
    if (sz == 0) flt = 1'b1;
    else if (s1 != 4'b0000 && !SPLIT) flt = 1'b1;
    else nb = (s1 != 4'b0000) ? 2 : 1;
  endfunction

  always @(negedge clk) begin
    if (!rst && mem_valid && mem_ready) begin
      if (q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        beat_t e;
        e = q.pop_front();
        check("beat_addr", mem_addr, e.addr);
        check("beat_strb", mem_wstrb, e.strb);
        check("beat_data", mem_wdata & bmask(e.strb), e.data);
      end
    end
    if (!rst && (done || fault)) check("done_fault_excl", done && fault, 0);
  end

  task automatic accept(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output bit flt, output int nb);
    int w;
    beat_t b0, b1;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("req_ready_to", req_ready, 1);
    model(f3, a, d, flt, nb, b0, b1);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_addr   = a;
    req_data   = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    if (!flt) begin
      q.push_back(b0);
      if (nb == 2) q.push_back(b1);
    end
    check("acc_valid", mem_valid, !flt);
    check("acc_fault", fault, flt);
  endtask

  task automatic finish_store(input int nb, input bit rnd);
    int cyc;
    cyc = 0;
    while (!done && cyc < 60) begin
      if (rnd) mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", done, 1);
    if (!rnd) check("latency", cyc, nb);
    check("q_empty", q.size(), 0);
    mem_ready = 1'b1;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input bit rnd);
    bit flt;
    int nb;
    accept(f3, a, d, flt, nb);
    if (!flt) finish_store(nb, rnd);
  endtask

  initial begin
    bit flt;
    int nb;
    logic [2:0] f3;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", mem_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_rst", req_ready, 1);

    do_store(3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
    do_store(3'b000, 32'h0000_2003, 32'h1234_56AB, 1'b0);
    do_store(3'b010, 32'h0000_3002, 32'hAABB_CCDD, 1'b0);
    do_store(3'b001, 32'hFFFF_FFFF, 32'h1234_BEEF, 1'b0);
    do_store(3'b001, 32'h0000_2001, 32'h5555_A1B2, 1'b0);
    do_store(3'b001, 32'h0000_2002, 32'h0000_C3D4, 1'b0);
    for (int o = 0; o < 4; o++)
      do_store(3'b000, 32'h0000_7000 + 32'(o), 32'h0000_0010 + 32'(o), 1'b0);

    accept(3'b100, 32'h0000_1000, 32'h1111_1111, flt, nb);
    do_store(3'b010, 32'h0000_1004, 32'h0BAD_F00D, 1'b0);
    accept(3'b111, 32'h0000_1008, 32'h2222_2222, flt, nb);
    @(posedge clk); #1;
    check("fault_one_cycle", fault, 0);
    check("fault_no_valid", mem_valid, 0);

    mem_ready = 1'b0;
    accept(3'b010, 32'h0000_5004, 32'hCAFE_F00D, flt, nb);
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", mem_valid, 1);
      check("hold_addr", mem_addr, 32'h0000_5004);
      check("hold_strb", mem_wstrb, 4'b1111);
      check("hold_data", mem_wdata, 32'hCAFE_F00D);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    finish_store(1, 1'b1);

    mem_ready = 1'b0;
    accept(3'b010, 32'h0000_6000, 32'h600D_600D, flt, nb);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", mem_valid, 0);
    check("mid_rst_done", done, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", req_ready, 1);
    check("post_rst_valid", mem_valid, 0);
    check("post_rst_done", done, 0);
    check("post_rst_fault", fault, 0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b011;
        default: f3 = 3'b100 | 3'($urandom_range(0, 3));
      endcase
      do_store(f3, $urandom, $urandom, 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_q_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
